fanout_fork: RTL and testbench
==============================

Name: fanout_fork

Overview:
Parametrised ready/valid broadcast fork for the sparse-stream fabric. It replaces the fixed six-way combinational "all selected consumers ready" fanout with an N-way fork. The fork has a per-output participation mask and an eager mode: per-output "taken" flags let each consumer accept the current token independently. Upstream sees in_ready once every participating consumer has taken the token. It sits between a stream producer (e.g. a primitive's output port) and the switch-box fanout to multiple consumers.

Parameters:
NUM_OUT, 6, number of output channels (1..16)
DATA_WIDTH, 17, token width (data plus stop/done flag bit)
CNT_WIDTH, 16, width of accepted-token counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_en  in  NUM_OUT  per-output participation mask; 1 = channel must take every token
cfg_eager  in  1  1 = eager fork (taken flags), 0 = lazy fork (legacy all-ready AND)
flush  in  1  synchronous clear of taken flags and counter
in_data  in  DATA_WIDTH  upstream token
in_valid  in  1  upstream valid
in_ready  out  1  upstream ready
out_data  out  DATA_WIDTH  broadcast copy of in_data (combinational)
out_valid  out  NUM_OUT  per-channel valid
out_ready  in  NUM_OUT  per-channel ready
taken  out  NUM_OUT  registered taken flags (debug/status)
tok_count  out  CNT_WIDTH  number of upstream handshakes since reset/flush, wraps modulo 2^CNT_WIDTH

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset: taken=0 and tok_count=0. While rst_n=0, in_ready=0 and out_valid=0 regardless of inputs. out_data always follows in_data.
- Notation: act[i]=cfg_en[i]; fire_o[i]=out_valid[i]&out_ready[i]; fire_in=in_valid&in_ready.
- Eager mode (cfg_eager=1):
  - out_valid[i] = in_valid & act[i] & ~taken[i].
  - in_ready = AND over i of (~act[i] | taken[i] | out_ready[i]).
  - Next-state: if fire_in, taken <= 0. Else taken[i] <= taken[i] | fire_o[i].
  - A channel that has taken the current token holds out_valid=0 until the next token.
  - Zero-cycle latency when all channels are ready. Otherwise in_ready rises in the cycle the last outstanding channel is ready.
- Lazy mode (cfg_eager=0):
  - in_ready = AND over i of (~act[i] | out_ready[i]).
  - out_valid[i] = in_valid & act[i] & in_ready.
  - taken stays 0. This mode is bit-compatible with the legacy combinational fanout.
- Empty mask (cfg_en=0): in_ready=1 and all out_valid=0. Tokens are consumed and dropped (sink behaviour), and tok_count still increments.
- tok_count increments by 1 on every fire_in and wraps from 2^CNT_WIDTH-1 to 0.
- flush=1: taken <= 0 and tok_count <= 0. flush overrides fire_in updates in the same cycle; an upstream handshake in that cycle still completes combinationally.
- cfg_en and cfg_eager are static configuration. They may change only when all taken=0; otherwise behaviour is undefined.
- Reset mid-token: all taken flags clear, so a partially delivered token is redelivered to every participating channel once rst_n returns high.
- in_valid may drop without a handshake (no upstream hold requirement). taken is kept, and a new in_valid is treated as the same token until fire_in. Producers must hold in_data while in_valid is asserted.

Test Plan:
- Reset: NUM_OUT=6, rst_n=0 for 3 cycles, in_valid=1, out_ready=all 1 -> in_ready=0, out_valid=0; after release taken=0, tok_count=0.
- Eager staggered accept: cfg_en=6'b000111, eager, in_valid=1 held. out_ready cycles: c0=001, c1=100, c2=010. Required:
  - c0: taken=001, in_ready=0
  - c1: taken=101, out_valid=010
  - c2: in_ready=1, tok_count 0->1, taken cleared to 0
- Lazy equivalence: cfg_eager=0, cfg_en=6'b101001, 200 random in_valid/out_ready cycles -> in_ready equals AND over (~cfg_en|out_ready) every cycle; taken stays 0.
- Empty mask sink: cfg_en=0, in_valid=1 for 5 cycles -> in_ready=1, out_valid=0, tok_count=5.
- Counter wrap and flush:
  - CNT_WIDTH=4, 17 back-to-back tokens with all ready -> tok_count=1.
  - flush with taken=011 -> next cycle taken=0, tok_count=0.
- Reset mid-token: eager, cfg_en=111, channel 0 taken, then rst_n=0 one cycle, then release -> out_valid=111 while in_valid=1.

Source files
------------

// File: rtl/fanout_fork.sv
// rtl/fanout_fork.sv - N-way ready/valid broadcast fork with eager taken flags or lazy all-ready mode
module fanout_fork #(
  parameter int NUM_OUT    = 6,
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic                  cfg_eager,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [NUM_OUT-1:0]    taken,
  output logic [CNT_WIDTH-1:0]  tok_count
);

  logic               lazy_ready;
  logic               eager_ready;
  logic               fire_in;
  logic [NUM_OUT-1:0] fire_o;

  // A channel blocks upstream only while it participates, still owes the token and is not ready.
  assign lazy_ready  = ~|(cfg_en & ~out_ready);
  assign eager_ready = ~|(cfg_en & ~taken & ~out_ready);

  assign out_data = in_data;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = '0;
    if (rst_n) begin
      if (cfg_eager) begin
        in_ready  = eager_ready;
        out_valid = {NUM_OUT{in_valid}} & cfg_en & ~taken;
      end else begin
        in_ready  = lazy_ready;
        out_valid = {NUM_OUT{in_valid & lazy_ready}} & cfg_en;
      end
    end
  end

  assign fire_in = in_valid & in_ready;
  assign fire_o  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken     <= '0;
      tok_count <= '0;
    end else if (flush) begin
      taken     <= '0;
      tok_count <= '0;
    end else begin
      if (fire_in) begin
        tok_count <= tok_count + CNT_WIDTH'(1);
      end
      // Lazy mode never records partial delivery, so its flags stay clear.
      if (fire_in || !cfg_eager) begin
        taken <= '0;
      end else begin
        taken <= taken | fire_o;
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork.sv
// tb/tb_fanout_fork.sv - directed and random checks of fanout_fork against a token scoreboard
module tb_fanout_fork;
  localparam int N  = 6;
  localparam int DW = 17;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  cfg_en;
  logic          cfg_eager;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N-1:0]  taken;
  logic [CW-1:0] tok_count;

  fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_eager(cfg_eager), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .tok_count(tok_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  logic [N-1:0]  m_taken;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    logic r = rst_n;
    for (int i = 0; i < N; i++)
      if (cfg_en[i] && !(out_ready[i] || (cfg_eager && m_taken[i]))) r = 1'b0;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      v[i] = rst_n & in_valid & cfg_en[i] & (cfg_eager ? ~m_taken[i] : exp_ready());
    return v;
  endfunction

  task automatic new_token();
    in_data = DW'($urandom);
    sb.push_back(in_data);
  endtask

  // One clock: compare combinational outputs at the falling edge, then advance the model.
  task automatic tick(input bit do_chk);
    logic         fire;
    logic [N-1:0] fo;
    @(negedge clk);
    fire = in_valid & exp_ready();
    fo   = exp_valid() & out_ready;
    if (do_chk) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("out_valid", 32'(out_valid), 32'(exp_valid()));
    end
    if (fire) begin
      if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
      else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_taken = '0; m_cnt = '0;
    end else if (flush) begin
      m_taken = '0; m_cnt = '0;
    end else begin
      if (fire) m_cnt = m_cnt + 1'b1;
      if (fire || !cfg_eager) m_taken = '0;
      else m_taken = m_taken | fo;
    end
    #1;
    if (do_chk) begin
      chk("taken", 32'(taken), 32'(m_taken));
      chk("tok_count", 32'(tok_count), 32'(m_cnt));
    end
  endtask

  initial begin
    m_taken = '0; m_cnt = '0;
    rst_n = 1'b0; cfg_en = 6'b000111; cfg_eager = 1'b1; flush = 1'b0;
    in_data = '0; in_valid = 1'b1; out_ready = '1;
    @(posedge clk); #1;

    // Reset holds the handshake closed.
    repeat (3) begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      tick(1'b0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_cnt", 32'(tok_count), 32'd0);
    tick(1'b1);

    // Eager staggered accept.
    new_token(); in_valid = 1'b1; out_ready = 6'b000001;
    tick(1'b1);
    chk("c0_taken", 32'(taken), 32'h01);
    chk("c0_in_ready", 32'(in_ready), 32'd0);
    out_ready = 6'b000100;
    tick(1'b1);
    chk("c1_taken", 32'(taken), 32'h05);
    chk("c1_out_valid", 32'(out_valid), 32'h02);
    out_ready = 6'b000010;
    #1;
    chk("c2_in_ready", 32'(in_ready), 32'd1);
    tick(1'b1);
    chk("c2_cnt", 32'(tok_count), 32'd1);
    chk("c2_taken", 32'(taken), 32'd0);

    // Lazy mode against the legacy AND.
    in_valid = 1'b0; cfg_eager = 1'b0; cfg_en = 6'b101001;
    new_token();
    for (int k = 0; k < 200; k++) begin
      in_valid  = 1'($urandom);
      out_ready = N'($urandom);
      #1;
      chk("lazy_and", 32'(in_ready), 32'(~|(cfg_en & ~out_ready)));
      tick(1'b1);
      if (sb.size() == 0) new_token();
    end
    in_valid = 1'b0; sb.delete();

    // Empty mask behaves as a sink.
    cfg_en = '0; cfg_eager = 1'b1; flush = 1'b1;
    tick(1'b1);
    flush = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      new_token();
      tick(1'b1);
    end
    chk("sink_in_ready", 32'(in_ready), 32'd1);
    chk("sink_out_valid", 32'(out_valid), 32'd0);
    chk("sink_cnt", 32'(tok_count), 32'd5);

    // 17 tokens wrap a 4-bit counter to 1.
    cfg_en = '1; out_ready = '1; in_valid = 1'b0; flush = 1'b1;
    tick(1'b1);
    flush = 1'b0; in_valid = 1'b1;
    repeat (17) begin
      new_token();
      tick(1'b1);
    end
    chk("wrap_cnt", 32'(tok_count), 32'd1);

    // Flush with a partially delivered token.
    in_valid = 1'b0; cfg_en = 6'b000111;
    tick(1'b1);
    new_token(); in_valid = 1'b1; out_ready = 6'b000011;
    tick(1'b1);
    chk("pre_flush_taken", 32'(taken), 32'h03);
    flush = 1'b1; out_ready = '0;
    tick(1'b1);
    flush = 1'b0;
    chk("flush_taken", 32'(taken), 32'd0);
    chk("flush_cnt", 32'(tok_count), 32'd0);

    // Reset mid-token redelivers to every channel.
    out_ready = 6'b000001;
    tick(1'b1);
    chk("mid_taken", 32'(taken), 32'h01);
    out_ready = '0; rst_n = 1'b0;
    tick(1'b1);
    rst_n = 1'b1;
    #1;
    chk("redeliver_valid", 32'(out_valid), 32'h07);
    out_ready = '1;
    tick(1'b1);
    chk("redeliver_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
